timing_sequencer: RTL
=====================

Name: timing_sequencer

Overview:
- Parametrised sequence counter and one-hot time-step generator for the control unit.
- Keeps the current instruction step in a counter and drives one time-step strobe per step, T0..T(STEPS-1), into the control-word logic.
- Adds clear, load/jump, hold, a selectable wrap or saturate mode, and error flags beyond a fixed 4-to-16 decode.

Parameters:
- STEPS, 16, number of time steps; legal range 2..64.
- CNT_W, $clog2(STEPS), counter width; derived, never overridden.
- WRAP_EN, 1, 1 = advance from last step wraps to 0; 0 = saturate at last step and flag overrun.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst_n  in  1  reset; asynchronous, active-low.
- Clear  in  1  step counter returns to 0 next edge (end of instruction / interrupt entry).
- Load  in  1  step counter takes LoadValue next edge.
- LoadValue  in  CNT_W  jump target step.
- Enable  in  1  advance one step; 0 = hold.
- ErrClr  in  1  clears the sticky error flags.
- StepCounter  out  CNT_W  current step index, registered.
- TimeSteps  out  STEPS  one-hot decode of StepCounter, registered.
- Wrap  out  1  one-cycle pulse on a last-step-to-0 advance.
- Overrun  out  1  sticky; Enable at last step with WRAP_EN=0.
- LoadErr  out  1  sticky; Load with LoadValue >= STEPS.

Behaviour:
- Reset (Rst_n low, asynchronous, any time including mid-instruction):
  - StepCounter = 0.
  - TimeSteps = 1 (T0 only).
  - Wrap = 0, Overrun = 0, LoadErr = 0.
- Release of Rst_n is synchronised externally; the first edge after release evaluates normally.
- Priority on each rising edge: Clear > Load > Enable > hold. Exactly one action is taken.
- Clear: next StepCounter = 0, next TimeSteps = 1. Load and Enable in the same cycle are ignored; LoadErr is not set by the ignored Load.
- Load, valid (LoadValue < STEPS): next StepCounter = LoadValue.
- Load, invalid (LoadValue >= STEPS):
  - StepCounter holds.
  - LoadErr is set.
  - Enable in the same cycle is ignored.
- Enable, StepCounter < STEPS-1: StepCounter increments by 1.
- Enable, StepCounter == STEPS-1, WRAP_EN=1: next StepCounter = 0; Wrap = 1 for exactly that cycle.
- Enable, StepCounter == STEPS-1, WRAP_EN=0: StepCounter holds at STEPS-1; Overrun is set; Wrap stays 0.
- Hold (no action): all registers keep their value; Wrap = 0.
- TimeSteps:
  - Registered in the same edge as StepCounter, from the next-state value.
  - Invariant: TimeSteps == (1 << StepCounter) every cycle; exactly one bit set; zero latency relative to StepCounter.
- Wrap is registered and is 0 on every cycle that is not a wrap advance.
- Sticky flags:
  - Cleared by ErrClr on the next edge.
  - If a set condition and ErrClr coincide, the set wins (flag = 1).
- When STEPS is not a power of 2, counter codes >= STEPS are unreachable. The decoder maps them to all-zero TimeSteps, and an assertion flags them.
- Cycle-level:
  - Enable held high from step 0 gives T0, T1, T2... on consecutive cycles.
  - Clear takes effect the cycle after assertion; T0 is visible the following cycle.

Decomposition:
- Package cu_pkg:
  - STEP_T0..STEP_T15 index constants.
  - Step-index typedef sized by CNT_W.
  - Shared by the control-word logic.
- One sub-module, onehot_decoder #(N, W): purely combinational W-to-N one-hot decode with an out-of-range-to-zero rule. It is instantiated once on the next-state counter, ahead of the TimeSteps register.

Test Plan:
- Reset: Rst_n=0 mid-count at step 7 -> StepCounter=0 and TimeSteps=16'h0001 immediately, without waiting for a clock edge; all flags 0.
- Count and wrap (STEPS=16, WRAP_EN=1): Enable=1 for 17 cycles from 0 -> TimeSteps walks 0x0001..0x8000 then 0x0001; Wrap=1 only on the 15->0 cycle.
- Saturate (WRAP_EN=0): Enable at step 15 -> StepCounter stays 15, TimeSteps=0x8000, Overrun=1; ErrClr=1 -> Overrun=0 next cycle.
- Priority: Clear=1, Load=1 (LoadValue=5), Enable=1 at step 3 -> next StepCounter=0, TimeSteps=0x0001, LoadErr=0.
- Load:
  - Load=1, LoadValue=9 at step 2 -> StepCounter=9, TimeSteps=0x0200.
  - STEPS=12, LoadValue=13 -> StepCounter holds, LoadErr=1.
  - LoadErr sets together with ErrClr -> LoadErr stays 1.
- Hold: Enable=0 for 5 cycles at step 4 -> StepCounter=4 and TimeSteps=0x0010 throughout; Wrap=0.

Source files
------------

// File: rtl/cu_pkg.sv
// -----------------------------------------------------------------------------
// cu_pkg -- shared definitions for the control unit timing path.
//
// Contents:
//   - STEP_T0..STEP_T15 : index constants naming each time step of the default
//                         16-step sequencer, so control-word logic can write
//                         timeSteps[STEP_T3] instead of a bare number.
//   - stepIdx_t         : step-index type sized for the default step count.
//   - stepAction_t      : the single action taken by the sequencer per edge.
// -----------------------------------------------------------------------------
package cu_pkg;

  localparam int DEFAULT_STEPS = 16;
  localparam int DEFAULT_CNT_W = $clog2(DEFAULT_STEPS);

  typedef logic [DEFAULT_CNT_W-1:0] stepIdx_t;

  localparam stepIdx_t STEP_T0  = stepIdx_t'(0);
  localparam stepIdx_t STEP_T1  = stepIdx_t'(1);
  localparam stepIdx_t STEP_T2  = stepIdx_t'(2);
  localparam stepIdx_t STEP_T3  = stepIdx_t'(3);
  localparam stepIdx_t STEP_T4  = stepIdx_t'(4);
  localparam stepIdx_t STEP_T5  = stepIdx_t'(5);
  localparam stepIdx_t STEP_T6  = stepIdx_t'(6);
  localparam stepIdx_t STEP_T7  = stepIdx_t'(7);
  localparam stepIdx_t STEP_T8  = stepIdx_t'(8);
  localparam stepIdx_t STEP_T9  = stepIdx_t'(9);
  localparam stepIdx_t STEP_T10 = stepIdx_t'(10);
  localparam stepIdx_t STEP_T11 = stepIdx_t'(11);
  localparam stepIdx_t STEP_T12 = stepIdx_t'(12);
  localparam stepIdx_t STEP_T13 = stepIdx_t'(13);
  localparam stepIdx_t STEP_T14 = stepIdx_t'(14);
  localparam stepIdx_t STEP_T15 = stepIdx_t'(15);

  // Exactly one of these is chosen on every rising edge; the priority order
  // Clear > Load > Enable > hold is resolved when the action is selected.
  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_CLEAR,
    ACT_LOAD,
    ACT_LOAD_ERR,
    ACT_ADVANCE
  } stepAction_t;

endpackage : cu_pkg

// File: rtl/onehot_decoder.sv
// -----------------------------------------------------------------------------
// onehot_decoder -- purely combinational W-to-N one-hot decode.
//
// Parameters:
//   N : number of output lines.
//   W : index width.
// Ports:
//   Idx    in  W  index to decode.
//   OneHot out N  bit Idx set; all zero when Idx >= N (unreachable codes of a
//                 non-power-of-two step count must not light any strobe).
// -----------------------------------------------------------------------------
module onehot_decoder
  import cu_pkg::*;
#(
  parameter int N = DEFAULT_STEPS,
  parameter int W = DEFAULT_CNT_W
) (
  input  logic [W-1:0] Idx,
  output logic [N-1:0] OneHot
);

  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    OneHot = '0;
    if (int'(Idx) < N) begin
      OneHot[Idx] = 1'b1;
    end
  end

endmodule : onehot_decoder

// File: rtl/timing_sequencer.sv
// -----------------------------------------------------------------------------
// timing_sequencer -- instruction step counter and one-hot time-step strobes.
//
// Parameters:
//   STEPS   : number of time steps (2..64).
//   WRAP_EN : 1 = advancing past the last step wraps to 0 with a Wrap pulse;
//             0 = the counter saturates at the last step and flags Overrun.
//   CNT_W   : counter width, derived from STEPS.
// Ports:
//   Clk, Rst_n  : clock (rising edge) and asynchronous active-low reset.
//   Clear       : return to step 0 on the next edge (highest priority).
//   Load        : jump to LoadValue on the next edge.
//   LoadValue   : jump target; values >= STEPS are rejected and set LoadErr.
//   Enable      : advance one step; low means hold.
//   ErrClr      : clears the sticky Overrun / LoadErr flags.
//   StepCounter : current step, registered.
//   TimeSteps   : registered one-hot of StepCounter (T0..T(STEPS-1)).
//   Wrap        : one-cycle pulse on a last-step-to-0 advance.
//   Overrun     : sticky, Enable at the last step while saturating.
//   LoadErr     : sticky, Load with an out-of-range LoadValue.
// -----------------------------------------------------------------------------
module timing_sequencer
  import cu_pkg::*;
#(
  parameter int  STEPS   = 16,
  parameter bit  WRAP_EN = 1'b1,
  localparam int CNT_W   = $clog2(STEPS)
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Clear,
  input  logic             Load,
  input  logic [CNT_W-1:0] LoadValue,
  input  logic             Enable,
  input  logic             ErrClr,
  output logic [CNT_W-1:0] StepCounter,
  output logic [STEPS-1:0] TimeSteps,
  output logic             Wrap,
  output logic             Overrun,
  output logic             LoadErr
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  stepAction_t      action;
  logic [CNT_W-1:0] nextCount;
  logic [STEPS-1:0] nextSteps;
  logic             nextWrap;
  logic             setOverrun;
  logic             setLoadErr;
  logic             loadValid;
  logic             atLast;

  assign loadValid = int'(LoadValue) < STEPS;
  assign atLast    = StepCounter == LAST_STEP;

  // Resolve the priority once, so the datapath below only sees one action.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    action = ACT_HOLD;
    if (Clear) begin
      action = ACT_CLEAR;
    end else if (Load) begin
      action = loadValid ? ACT_LOAD : ACT_LOAD_ERR;
    end else if (Enable) begin
      action = ACT_ADVANCE;
    end
  end

  always_comb begin
    nextCount  = StepCounter;
    nextWrap   = 1'b0;
    setOverrun = 1'b0;
    setLoadErr = 1'b0;
    unique case (action)
      ACT_CLEAR:    nextCount = '0;
      ACT_LOAD:     nextCount = LoadValue;
      ACT_LOAD_ERR: setLoadErr = 1'b1;  // rejected jump: counter holds
      ACT_ADVANCE: begin
        if (!atLast) begin
          nextCount = StepCounter + CNT_W'(1);
        end else if (WRAP_EN) begin
          nextCount = '0;
          nextWrap  = 1'b1;
        end else begin
          setOverrun = 1'b1;  // saturate at the last step
        end
      end
      default: ;
    endcase
  end

  // Decoding the next-state count lets TimeSteps be registered on the same edge
  // as StepCounter, so the strobes have zero latency relative to the counter.
  onehot_decoder #(
    .N (STEPS),
    .W (CNT_W)
  ) u_decoder (
    .Idx    (nextCount),
    .OneHot (nextSteps)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      StepCounter <= '0;
      TimeSteps   <= STEPS'(1);
      Wrap        <= 1'b0;
      Overrun     <= 1'b0;
      LoadErr     <= 1'b0;
    end else begin
      StepCounter <= nextCount;
      TimeSteps   <= nextSteps;
      Wrap        <= nextWrap;
      // A set condition wins over a simultaneous ErrClr.
      Overrun     <= setOverrun | (Overrun & ~ErrClr);
      LoadErr     <= setLoadErr | (LoadErr & ~ErrClr);
    end
  end

  // Codes >= STEPS can never be reached; catch them and any loss of one-hotness.
  assert property (@(posedge Clk) disable iff (!Rst_n)
                   (int'(StepCounter) < STEPS) && $onehot(TimeSteps));

endmodule : timing_sequencer
